// File: rtl/button_enable_gen.sv
// Debounced push-button to single-cycle enable pulse generator with optional auto-repeat.
// Raw button is synchronised, debounced by a four-state FSM, and turned into registered pulses.
module button_enable_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    input  logic auto_mode,
    output logic enable_out,
    output logic button_level
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);

    state_t      state, state_next;
    logic        sync1, sync2;
    logic [7:0]  deb_cnt, deb_next;
    logic [15:0] rep_cnt, rep_next;
    logic        enable_next, level_next;
    logic        initial_fire, repeat_fire;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            deb_cnt      <= '0;
            rep_cnt      <= '0;
            enable_out   <= 1'b0;
            button_level <= 1'b0;
        end else begin
            state        <= state_next;
            deb_cnt      <= deb_next;
            rep_cnt      <= rep_next;
            enable_out   <= enable_next;
            button_level <= level_next;
        end
    end

    // NOTE: defaults first keep every branch assigned, so no latches are inferred.
    always_comb begin
        state_next = state;
        deb_next   = deb_cnt;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_next = PRESS_WAIT;
                    deb_next   = 8'd1;
                end
            end
            PRESS_WAIT: begin
                if (!sync2) begin
                    state_next = IDLE;
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = PRESSED;
                    deb_next   = '0;
                end else begin
                    deb_next = deb_cnt + 8'd1;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_next = RELEASE_WAIT;
                    deb_next   = 8'd1;
                end
            end
            RELEASE_WAIT: begin
                if (sync2) begin
                    state_next = PRESSED;
                    deb_next   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_next = IDLE;
                    deb_next   = '0;
                end else begin
                    deb_next = deb_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                deb_next   = '0;
            end
        endcase
    end

    // Repeat period restarts whenever the button leaves PRESSED or auto_mode drops.
    always_comb begin
        rep_next    = '0;
        repeat_fire = 1'b0;
        if (state == PRESSED && auto_mode) begin
            if (rep_cnt == REP_LAST) begin
                repeat_fire = 1'b1;
            end else begin
                rep_next = rep_cnt + 16'd1;
            end
        end
        initial_fire = (state == PRESS_WAIT) && (state_next == PRESSED);
        enable_next  = (initial_fire || repeat_fire) && !enable_out;
        level_next   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_button_enable_gen.sv
// Bench for button_enable_gen: two instances (D=4,P=10 and D=1,P=2) against a run-length model,
// plus hand-computed pulse/level timing for directed scenarios.
module tb_button_enable_gen;

    logic clk;
    logic reset, button_in, auto_mode;
    logic en0, lv0, en1, lv1;

    button_enable_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10)) u_dut0 (
        .clock(clk), .reset(reset), .button_in(button_in), .auto_mode(auto_mode),
        .enable_out(en0), .button_level(lv0)
    );

    button_enable_gen #(.DEBOUNCE_CYCLES(1), .REPEAT_CYCLES(2)) u_dut1 (
        .clock(clk), .reset(reset), .button_in(button_in), .auto_mode(auto_mode),
        .enable_out(en1), .button_level(lv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: accept a new level after D+1 consecutive disagreeing synchronised samples;
    // repeats fire when the stable-pressed-with-auto streak is a multiple of P.
    typedef struct packed {
        logic s1;
        logic s2;
        int   run;
        logic acc;
        int   streak;
        logic en;
    } model_t;

    function automatic model_t model_step(model_t m, logic rst, logic b, logic a, int d, int p);
        model_t n;
        logic   vis;
        n = m;
        if (rst) begin
            n = '0;
            return n;
        end
        vis  = m.s2;
        n.s2 = m.s1;
        n.s1 = b;
        n.en = 1'b0;
        if (m.acc && m.run == 0 && a) begin
            n.streak = m.streak + 1;
            if (n.streak % p == 0) n.en = 1'b1;
        end else begin
            n.streak = 0;
        end
        if (vis != m.acc) begin
            n.run = m.run + 1;
            if (n.run == d + 1) begin
                n.acc = !m.acc;
                n.run = 0;
                if (n.acc) n.en = 1'b1;
            end
        end else begin
            n.run = 0;
        end
        return n;
    endfunction

    model_t m0 = '0;
    model_t m1 = '0;
    int     edge_n = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    int     p0[$], p1[$], f0[$], f1[$];
    logic   lv0_q = 1'b0;
    logic   lv1_q = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1000;
    endfunction

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        m0 = model_step(m0, reset, button_in, auto_mode, 4, 10);
        m1 = model_step(m1, reset, button_in, auto_mode, 1, 2);
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            check("en_d4", int'(en0), int'(m0.en));
            check("level_d4", int'(lv0), int'(m0.acc));
            check("en_d1", int'(en1), int'(m1.en));
            check("level_d1", int'(lv1), int'(m1.acc));
            if (en0) p0.push_back(edge_n);
            if (en1) p1.push_back(edge_n);
            if (lv0_q && !lv0) f0.push_back(edge_n);
            if (lv1_q && !lv1) f1.push_back(edge_n);
            lv0_q = lv0;
            lv1_q = lv1;
        end
    end

    // Applies the inputs for n edges; s is the first edge that samples them.
    task automatic drive(input logic b, input logic a, input logic r, input int n, output int s);
        s = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            button_in = b;
            auto_mode = a;
            reset     = r;
            if (i == 0) s = edge_n + 1;
        end
    endtask

    int s, t, a, b;

    initial begin
        reset     = 1'b1;
        button_in = 1'b0;
        auto_mode = 1'b0;
        drive(0, 0, 1, 3, s);
        drive(0, 0, 0, 5, s);

        // Clean press, auto off
        p0.delete(); p1.delete();
        drive(1, 0, 0, 20, s);
        check("press_pulses_d4", p0.size(), 1);
        check("press_latency_d4", at(p0, 0) - s, 6);
        check("press_pulses_d1", p1.size(), 1);
        check("press_latency_d1", at(p1, 0) - s, 3);
        check("press_level_d4", int'(lv0), 1);

        // Clean release
        p0.delete(); f0.delete(); f1.delete();
        drive(0, 0, 0, 12, s);
        check("release_fall_d4", at(f0, 0) - s, 6);
        check("release_fall_d1", at(f1, 0) - s, 3);
        check("release_no_pulse", p0.size(), 0);

        // Bounce 1,0,1,0 then steady
        p0.delete();
        drive(1, 0, 0, 1, s);
        drive(0, 0, 0, 1, t);
        drive(1, 0, 0, 1, t);
        drive(0, 0, 0, 1, t);
        drive(1, 0, 0, 15, t);
        check("bounce_pulses", p0.size(), 1);
        check("bounce_latency", at(p0, 0) - t, 6);

        // One-cycle release glitch while pressed
        p0.delete(); p1.delete(); f0.delete(); f1.delete();
        drive(0, 0, 0, 1, s);
        drive(1, 0, 0, 10, t);
        check("glitch_pulses_d4", p0.size(), 0);
        check("glitch_falls_d4", f0.size(), 0);
        check("glitch_pulses_d1", p1.size(), 0);
        check("glitch_falls_d1", f1.size(), 0);
        check("glitch_level_d4", int'(lv0), 1);
        drive(0, 0, 0, 12, s);

        // Auto-repeat held
        p0.delete();
        drive(1, 1, 0, 58, s);
        drive(0, 0, 0, 12, t);
        check("auto_pulses", p0.size(), 6);
        for (int i = 0; i < 6; i++) check("auto_pulse_edge", at(p0, i) - s, 6 + 10 * i);

        // auto_mode toggled while pressed
        p0.delete();
        drive(1, 0, 0, 15, s);
        drive(1, 1, 0, 25, a);
        drive(1, 0, 0, 5, t);
        drive(1, 1, 0, 12, b);
        drive(0, 0, 0, 12, t);
        check("toggle_pulses", p0.size(), 4);
        check("toggle_first_repeat", at(p0, 1) - a, 9);
        check("toggle_restart", at(p0, 3) - b, 9);

        // Reset in PRESS_WAIT with counter at 3, button held
        p0.delete();
        drive(1, 0, 0, 5, s);
        drive(1, 0, 1, 1, a);
        drive(1, 0, 0, 1, t);
        check("rst_pw_en", int'(en0), 0);
        check("rst_pw_level", int'(lv0), 0);
        drive(1, 0, 0, 15, b);
        check("rst_pw_pulses", p0.size(), 1);
        check("rst_pw_latency", at(p0, 0) - t, 6);

        // Reset while pressed with auto on, button held
        p0.delete();
        drive(1, 1, 0, 4, s);
        drive(1, 1, 1, 2, a);
        drive(1, 1, 0, 1, t);
        check("rst_pr_en", int'(en0), 0);
        check("rst_pr_level", int'(lv0), 0);
        drive(1, 1, 0, 15, b);
        drive(0, 0, 0, 12, b);
        check("rst_pr_pulses", p0.size(), 1);
        check("rst_pr_latency", at(p0, 0) - t, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
